inst_mem_loader: RTL and testbench

Boot-time writer for the instruction memory that the openmips core fetches from. It accepts a byte stream over a valid/ready handshake, parses a length header, and assembles big-endian 32-bit instruction words. It writes those words sequentially into instruction RAM and verifies an XOR checksum. It holds the CPU in reset until a load completes cleanly.

---
 rtl/inst_mem_loader.sv | 160 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Boot-time instruction RAM loader: parses a length-prefixed big-endian byte stream, writes words
// sequentially, verifies an XOR check byte and releases the CPU reset only after a clean load.
module inst_mem_loader #(
    parameter int unsigned ADDR_W    = 17,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {StIdle, StHdr, StData, StChk, StDone, StErr} state_e;

    localparam int unsigned IdxW     = ADDR_W + 1;
    localparam logic [32:0] MaxWords = 33'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       word_q, word_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_d   = cpu_rst_q;
        done_d      = done_q;
        err_d       = err_q;

        byte_ready = (state_q == StHdr) || (state_q == StData) || (state_q == StChk);
        busy       = byte_ready;
        accept     = byte_valid && byte_ready;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d   = StHdr;
                    n_d       = '0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    csum_d    = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cpu_rst_d = 1'b1;
                end
            end
            StHdr: begin
                if (accept) begin
                    n_d    = {n_q[23:0], byte_in};
                    csum_d = csum_q ^ byte_in;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if ({1'b0, n_d} > MaxWords) begin
                            state_d   = StErr;
                            err_d     = 1'b1;
                            cpu_rst_d = 1'b1;
                        end else if (n_d == 32'd0) begin
                            state_d = StChk;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (accept) begin
                    word_d = {word_q[15:0], byte_in};
                    csum_d = csum_q ^ byte_in;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + 32'({idx_q, 2'b00});
                        mem_wdata_d = {word_q, byte_in};
                        idx_d       = idx_q + 1'b1;
                        if (32'(idx_q) + 32'd1 == n_q) begin
                            state_d = StChk;
                        end
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    if (byte_in == csum_q) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d   = StErr;
                        err_d     = 1'b1;
                        cpu_rst_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (ADDR_W=4 so the oversize limit is reachable).
module tb_inst_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int failures;
    logic [63:0] wq[$];
    logic [7:0]  stream[$];

    inst_mem_loader #(
        .ADDR_W    (4),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, ".mem_we"}, 64'(mem_we), 64'd0);
        check({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, ".cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".err"}, 64'(err), 64'd0);
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".start_busy"}, 64'(busy), 64'd1);
        check({tag, ".start_ready"}, 64'(byte_ready), 64'd1);
        check({tag, ".start_clr"}, 64'({done, err, cpu_rst}), 64'b001);
    endtask

    // Present one byte after 'gap' idle cycles carrying junk data; return after it is accepted.
    task automatic send(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        repeat (gap) begin
            byte_in = ~b;
            @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && byte_ready !== 1'b1; i++) @(negedge clk);
        if (byte_ready !== 1'b1) check("send_ready_timeout", 64'(byte_ready), 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_all(input int gap);
        foreach (stream[i]) send(stream[i], gap);
    endtask

    task automatic set_good(input logic [7:0] chk);
        stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00,
                   8'h34, 8'h02, 8'h00, 8'h20};
        stream.push_back(chk);
    endtask

    task automatic check_good_writes(input string tag);
        check({tag, ".nwr"}, 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            check({tag, ".wr0"}, wq[0], {32'h0000_0000, 32'h3401_1100});
            check({tag, ".wr1"}, wq[1], {32'h0000_0004, 32'h3402_0020});
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'hA5;

        // Reset, with a byte offered that must not be taken
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", 64'(byte_ready), 64'd0);
        check("idle_state", 64'({busy, cpu_rst, done, err}), 64'b0100);
        byte_valid = 1'b0;

        // Good load, back-to-back
        wq.delete();
        do_start("good");
        set_good(8'h30);
        send_all(0);
        check("good.flags", 64'({done, err, cpu_rst, busy}), 64'b1000);
        check_good_writes("good");

        // Bad checksum
        wq.delete();
        do_start("bad");
        set_good(8'h31);
        send_all(0);
        check("bad.flags", 64'({done, err, cpu_rst, busy}), 64'b0110);
        check_good_writes("bad");
        do_start("bad_restart");
        check("bad_restart.err", 64'(err), 64'd0);

        // Oversize header, loader already in HDR from the restart above
        wq.delete();
        stream = '{8'h00, 8'h00, 8'h00, 8'h11};
        send_all(0);
        check("over.flags", 64'({done, err, cpu_rst, busy}), 64'b0110);
        check("over.ready", 64'(byte_ready), 64'd0);
        repeat (2) @(negedge clk);
        check("over.nwr", 64'(wq.size()), 64'd0);

        // N=16 at the capacity limit: words 0..15, check byte = 0x10 ^ (0^..^15) = 0x10
        wq.delete();
        do_start("full");
        stream = '{8'h00, 8'h00, 8'h00, 8'h10};
        for (int k = 0; k < 16; k++) begin
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            stream.push_back(8'(k));
        end
        stream.push_back(8'h10);
        send_all(0);
        check("full.flags", 64'({done, err, cpu_rst, busy}), 64'b1000);
        check("full.nwr", 64'(wq.size()), 64'd16);
        if (wq.size() == 16) begin
            check("full.first", wq[0], {32'h0000_0000, 32'h0000_0000});
            check("full.last", wq[15], {32'h0000_003C, 32'h0000_000F});
        end

        // Handshake gaps: valid every third cycle, junk data in between
        wq.delete();
        do_start("gap");
        set_good(8'h30);
        send_all(2);
        check("gap.flags", 64'({done, err, cpu_rst, busy}), 64'b1000);
        check_good_writes("gap");

        // Ignored start mid-DATA, then reset mid-DATA
        wq.delete();
        do_start("abort");
        stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h34, 8'h01};
        send_all(0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort.ign_busy", 64'(busy), 64'd1);
        stream = '{8'h11, 8'h00, 8'h34, 8'h02};
        send_all(0);
        check("abort.nwr1", 64'(wq.size()), 64'd1);
        if (wq.size() == 1) check("abort.wr0", wq[0], {32'h0000_0000, 32'h3401_1100});
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("abort_rst");
        rst        = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check("abort.nwr_after", 64'(wq.size()), 64'd1);
        check("abort.idle", 64'({busy, cpu_rst}), 64'b01);

        // Empty image
        wq.delete();
        do_start("empty");
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all(0);
        check("empty.flags", 64'({done, err, cpu_rst, busy}), 64'b1000);
        check("empty.nwr", 64'(wq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
